// File: rtl/e_cycle_sequencer_if.sv
// Bus bundle between the CPU-side glue in main_top and the E-clock sequencer.
// The sequencer uses the slave modport; the CPU-side logic (or a bench) uses master.
interface e_cycle_sequencer_if;
  logic       AS_CPU_n;
  logic       VPA_n;
  logic [2:0] FC;
  logic       E;
  logic       VMA_n;
  logic       DTACK_REQ_n;
  logic [3:0] E_CNT;

  modport master (
    output AS_CPU_n, VPA_n, FC,
    input  E, VMA_n, DTACK_REQ_n, E_CNT
  );

  modport slave (
    input  AS_CPU_n, VPA_n, FC,
    output E, VMA_n, DTACK_REQ_n, E_CNT
  );
endinterface

// File: rtl/e_cycle_sequencer.sv
// 68000-style E clock generator and 6800 peripheral (VPA/VMA) cycle sequencer on C7M.
// Optional macro SF500_FAST_AVEC_EN: interrupt-acknowledge cycles skip E synchronization.
module e_cycle_sequencer #(
  parameter int unsigned E_LOW       = 6,
  parameter int unsigned E_HIGH      = 4,
  parameter int unsigned VMA_LAST    = 3,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               C7M,
  input  logic               RESET_n,
  e_cycle_sequencer_if.slave bus
);

  localparam int unsigned E_PERIOD     = E_LOW + E_HIGH;
  localparam logic [3:0]  CNT_LAST     = 4'(E_PERIOD - 1);
  localparam logic [3:0]  CNT_TERM     = 4'(E_PERIOD - 3);
  localparam logic [3:0]  CNT_VMA_LAST = 4'(VMA_LAST);
  localparam logic [3:0]  CNT_E_RISE   = 4'(E_LOW);

  typedef enum logic [2:0] {IDLE, WAIT, VMA, TERM, DONE} state_t;

  // ---------------------------------------------------------------------------
  // E phase counter and registered E
  // ---------------------------------------------------------------------------
  logic [3:0] e_cnt;
  logic [3:0] e_cnt_nxt;
  logic       e_q;

  always_comb begin
    e_cnt_nxt = (e_cnt == CNT_LAST) ? 4'd0 : e_cnt + 4'd1;
  end

  // E is derived from the next count so that E and E_CNT change on the same edge.
  always_ff @(posedge C7M) begin
    if (!RESET_n) begin
      e_cnt <= 4'd0;
      e_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments for every register, so all flops see pre-edge values.
      e_cnt <= e_cnt_nxt;
      e_q   <= (e_cnt_nxt >= CNT_E_RISE);
    end
  end

  // ---------------------------------------------------------------------------
  // Input synchronizers (SYNC_STAGES >= 2)
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] as_sync;
  logic [SYNC_STAGES-1:0] vpa_sync;
  logic [SYNC_STAGES-1:0] sync_fill;
  logic                   as_s;
  logic                   vpa_s;
  logic                   sync_valid;

  always_ff @(posedge C7M) begin
    if (!RESET_n) begin
      as_sync   <= '1;
      vpa_sync  <= '1;
      sync_fill <= '0;
    end else begin
      as_sync   <= {as_sync[SYNC_STAGES-2:0], bus.AS_CPU_n};
      vpa_sync  <= {vpa_sync[SYNC_STAGES-2:0], bus.VPA_n};
      sync_fill <= {sync_fill[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign as_s       = as_sync[SYNC_STAGES-1];
  assign vpa_s      = vpa_sync[SYNC_STAGES-1];
  // The reset fill of 1s is not a real AS observation; only trust as_s once the pipe holds live samples.
  assign sync_valid = sync_fill[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Request qualification: a new cycle needs AS to have been seen high since the last one
  // ---------------------------------------------------------------------------
  logic as_seen_high_q;
  logic accept;
  logic req;

  assign req = !as_s && !vpa_s && as_seen_high_q;

  always_ff @(posedge C7M) begin
    if (!RESET_n) begin
      as_seen_high_q <= 1'b0;
    end else if (accept) begin
      as_seen_high_q <= 1'b0;
    end else if (as_s && sync_valid) begin
      as_seen_high_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Cycle FSM
  // ---------------------------------------------------------------------------
  state_t state;
  state_t state_nxt;
  logic   vma_n_q;
  logic   vma_n_nxt;
  logic   dtack_n_q;
  logic   dtack_n_nxt;

`ifdef SF500_FAST_AVEC_EN
  logic fast_arm_q;
  logic fast_arm_nxt;

  always_ff @(posedge C7M) begin
    if (!RESET_n) begin
      fast_arm_q <= 1'b0;
    end else begin
      fast_arm_q <= fast_arm_nxt;
    end
  end
`endif

  always_ff @(posedge C7M) begin
    if (!RESET_n) begin
      state     <= IDLE;
      vma_n_q   <= 1'b1;
      dtack_n_q <= 1'b1;
    end else begin
      state     <= state_nxt;
      vma_n_q   <= vma_n_nxt;
      dtack_n_q <= dtack_n_nxt;
    end
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_nxt   = state;
    vma_n_nxt   = 1'b1;
    dtack_n_nxt = 1'b1;
    accept      = 1'b0;
`ifdef SF500_FAST_AVEC_EN
    fast_arm_nxt = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (req) begin
          accept = 1'b1;
`ifdef SF500_FAST_AVEC_EN
          if (bus.FC == 3'b111) begin
            state_nxt = DONE;
          end else
`endif
          if (e_cnt <= CNT_VMA_LAST) begin
            state_nxt = VMA;
            vma_n_nxt = 1'b0;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (as_s) begin
          state_nxt = IDLE;
        end else if (e_cnt == CNT_LAST) begin
          state_nxt = VMA;
          vma_n_nxt = 1'b0;
        end
      end
      VMA: begin
        if (as_s) begin
          state_nxt = IDLE;
        end else begin
          vma_n_nxt = 1'b0;
          if (e_cnt == CNT_TERM) begin
            state_nxt   = TERM;
            dtack_n_nxt = 1'b0;
          end
        end
      end
      TERM: begin
        if (as_s) begin
          state_nxt = IDLE;
        end else begin
          vma_n_nxt   = 1'b0;
          dtack_n_nxt = 1'b0;
        end
      end
`ifdef SF500_FAST_AVEC_EN
      // One idle edge after acceptance, then DTACK until AS goes away.
      DONE: begin
        if (as_s) begin
          state_nxt = IDLE;
        end else begin
          fast_arm_nxt = 1'b1;
          dtack_n_nxt  = !fast_arm_q;
        end
      end
`endif
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.E           = e_q;
  assign bus.VMA_n       = vma_n_q;
  assign bus.DTACK_REQ_n = dtack_n_q;
  assign bus.E_CNT       = e_cnt;

endmodule
